// File: rtl/ntt_seq_pkg.sv
// Shared types and helpers for the sequenced NTT core.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ntt_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   // Twiddle selection modes; any value above MODE_WORD also indexes per word.
   localparam logic [1:0] MODE_SHARED = 2'd0;
   localparam logic [1:0] MODE_GROUP  = 2'd1;
   localparam logic [1:0] MODE_WORD   = 2'd2;

   localparam int unsigned DEF_DATA_W = 30;
   localparam int unsigned DEF_Q      = 998244353;

   // Stage twiddle base: 2^log_m plus this core's share of the stage offset.
   function automatic logic [31:0] tw_base(input logic [3:0]  log_m,
                                           input int unsigned core_index,
                                           input int unsigned log_core_count);
      logic [31:0] one_sh;
      logic [31:0] core_sh;
      one_sh  = 32'd1 << log_m;
      core_sh = (32'(core_index) << log_m) >> log_core_count;
      return one_sh + core_sh;
   endfunction

endpackage

// File: rtl/ntt_seq_butterfly.sv
// One Cooley-Tukey butterfly lane: A = a + w*b, B = a - w*b, both mod Q.
// Latency: BF_LAT cycles from in_vld to out_vld.
// Backpressure: en=0 freezes every stage, valid and data alike.
module ntt_seq_butterfly
   import ntt_seq_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned Q      = DEF_Q,
   parameter int unsigned BF_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] w,
   output logic              out_vld,
   output logic              any_vld,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b
);

   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   wb;
   logic [DATA_W:0]     sum;
   logic [DATA_W-1:0]   res_a;
   logic [DATA_W-1:0]   res_b;

   logic [BF_LAT-1:0]   vld_sr;
   logic [DATA_W-1:0]   a_sr [BF_LAT];
   logic [DATA_W-1:0]   b_sr [BF_LAT];

   // Modular butterfly computed ahead of the register chain; the trailing
   // stages give synthesis room to retime the multiply and reduction.
   always_comb begin
      prod  = {{DATA_W{1'b0}}, w} * {{DATA_W{1'b0}}, b};
      wb    = DATA_W'(prod % (2*DATA_W)'(Q));
      sum   = {1'b0, a} + {1'b0, wb};
      res_a = (sum >= (DATA_W+1)'(Q)) ? DATA_W'(sum - (DATA_W+1)'(Q)) : DATA_W'(sum);
      res_b = (a >= wb) ? DATA_W'({1'b0, a} - {1'b0, wb})
                        : DATA_W'({1'b0, a} + (DATA_W+1)'(Q) - {1'b0, wb});
   end

   // Valid and data shift together so a frozen stage keeps its pair intact.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_sr <= '0;
         for (int s = 0; s < BF_LAT; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
         end
      end else if (en) begin
         vld_sr[0] <= in_vld;
         a_sr[0]   <= res_a;
         b_sr[0]   <= res_b;
         for (int s = 1; s < BF_LAT; s++) begin
            vld_sr[s] <= vld_sr[s-1];
            a_sr[s]   <= a_sr[s-1];
            b_sr[s]   <= b_sr[s-1];
         end
      end
   end

   assign out_vld = vld_sr[BF_LAT-1];
   assign any_vld = |vld_sr;
   assign out_a   = a_sr[BF_LAT-1];
   assign out_b   = b_sr[BF_LAT-1];

endmodule

// File: rtl/ntt_core_seq.sv
// Sequenced NTT core: one pass of butterflies over a local coefficient RAM, results streamed in address order.
// Latency: start at cycle 0, result k valid in cycle 2+BF_LAT+k, done in cycle 3+BF_LAT+WORDS.
// Backpressure: none by default; with NTT_CORE_SEQ_BACKPRESSURE_EN, res_ready=0 freezes the whole pipeline.
module ntt_core_seq
   import ntt_seq_pkg::*;
#(
   parameter int unsigned LANES          = 2,
   parameter int unsigned DATA_W         = DEF_DATA_W,
   parameter int unsigned ADDR_W         = 9,
   parameter int unsigned Q              = DEF_Q,
   parameter int unsigned BF_LAT         = 3,
   parameter int unsigned CORE_INDEX     = 0,
   parameter int unsigned LOG_CORE_COUNT = 5,
   parameter int unsigned TW_W           = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [3:0]                 log_m,
   input  logic [9:0]                 i,
   input  logic [1:0]                 mode,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [2*LANES*DATA_W-1:0]  wr_data,
   output logic [LANES*TW_W-1:0]      tw_index,
   input  logic [LANES*DATA_W-1:0]    tw_data,
   output logic                       busy,
   output logic                       done,
   output logic                       res_valid,
   output logic [ADDR_W-1:0]          res_addr,
   output logic [2*LANES*DATA_W-1:0]  res_data
`ifdef NTT_CORE_SEQ_BACKPRESSURE_EN
   ,
   input  logic                       res_ready
`endif
);

   localparam int unsigned WORD_W = 2*LANES*DATA_W;

   seq_state_t         state_q;
   seq_state_t         state_d;
   logic [ADDR_W-1:0]  rd_cnt;
   logic               rd_en;
   logic               rd_vld;
   logic [WORD_W-1:0]  ram_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [TW_W-1:0]    base_q;
   logic [9:0]         i_q;
   logic [1:0]         mode_q;
   logic               adv;
   logic [LANES-1:0]   lane_vld;
   logic [LANES-1:0]   lane_any;
   logic               bf_any;
   logic [ADDR_W-1:0]  addr_sr [BF_LAT];
   logic [WORD_W-1:0]  mem [2**ADDR_W];

`ifdef NTT_CORE_SEQ_BACKPRESSURE_EN
   assign adv = !(res_valid && !res_ready);
`else
   assign adv = 1'b1;
`endif

   assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign res_valid = &lane_vld;
   assign bf_any    = |lane_any;
   assign res_addr  = addr_sr[BF_LAT-1];

   // Next state and read issue; the pass ends only once nothing is in flight.
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            rd_en = adv;
            if (adv && (rd_cnt == '1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!rd_vld && !bf_any) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register, pass parameters latched at start, read counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rd_cnt  <= '0;
         rd_vld  <= 1'b0;
         base_q  <= '0;
         i_q     <= '0;
         mode_q  <= MODE_SHARED;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IDLE) && start) begin
            rd_cnt <= '0;
            base_q <= TW_W'(tw_base(log_m, CORE_INDEX, LOG_CORE_COUNT));
            i_q    <= i;
            mode_q <= mode;
         end else if (rd_en) begin
            rd_cnt <= rd_cnt + ADDR_W'(1);
         end
         if (adv) rd_vld <= rd_en;
      end
   end

   // Load port; writes are dropped while a pass owns the RAM.
   always_ff @(posedge clk) begin
      if (wr_en && !busy) mem[wr_addr] <= wr_data;
   end

   // Registered RAM read with its address carried alongside for twiddles.
   always_ff @(posedge clk) begin
      if (adv) begin
         ram_q  <= mem[rd_cnt];
         addr_q <= rd_cnt;
      end
   end

   // Twiddle index per lane, aligned with the RAM word at the butterfly input.
   always_comb begin
      tw_index = '0;
      for (int j = 0; j < LANES; j++) begin
         case (mode_q)
            MODE_SHARED: tw_index[j*TW_W +: TW_W] = base_q;
            MODE_GROUP:  tw_index[j*TW_W +: TW_W] = TW_W'(32'(base_q) + (32'(i_q) << 1));
            default:     tw_index[j*TW_W +: TW_W] =
                            TW_W'(32'(base_q) + 32'(addr_q) * 32'(LANES) + 32'(j));
         endcase
      end
   end

   // Address delay line matching the butterfly depth.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < BF_LAT; s++) addr_sr[s] <= '0;
      end else if (adv) begin
         addr_sr[0] <= addr_q;
         for (int s = 1; s < BF_LAT; s++) addr_sr[s] <= addr_sr[s-1];
      end
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      ntt_seq_butterfly #(
         .DATA_W (DATA_W),
         .Q      (Q),
         .BF_LAT (BF_LAT)
      ) u_bf (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (adv),
         .in_vld  (rd_vld),
         .a       (ram_q[2*j*DATA_W +: DATA_W]),
         .b       (ram_q[(2*j+1)*DATA_W +: DATA_W]),
         .w       (tw_data[j*DATA_W +: DATA_W]),
         .out_vld (lane_vld[j]),
         .any_vld (lane_any[j]),
         .out_a   (res_data[2*j*DATA_W +: DATA_W]),
         .out_b   (res_data[(2*j+1)*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_ntt_core_seq.sv
// Self-checking bench for ntt_core_seq against a word-level reference model.
// Latency: checks result and done timing relative to the start cycle.
// Backpressure: exercises a 7-cycle res_ready stall when the feature macro is defined.
module tb_ntt_core_seq;

   localparam int LANES = 2, DATA_W = 30, ADDR_W = 9, BF_LAT = 3;
   localparam int CORE_INDEX = 4, LOG_CORE_COUNT = 5, TW_W = 12;
   localparam int WORDS = 1 << ADDR_W;
   localparam int WW = 2*LANES*DATA_W;
   localparam longint Q = 998244353;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic [3:0]               log_m = '0;
   logic [9:0]               i_in = '0;
   logic [1:0]               mode = '0;
   logic                     wr_en = 1'b0;
   logic [ADDR_W-1:0]        wr_addr = '0;
   logic [WW-1:0]            wr_data = '0;
   logic [LANES*TW_W-1:0]    tw_index;
   logic [LANES*DATA_W-1:0]  tw_data;
   logic                     busy, done, res_valid;
   logic [ADDR_W-1:0]        res_addr;
   logic [WW-1:0]            res_data;
   logic                     res_ready = 1'b1;

   int            edge_cnt = 0;
   bit            tw_force = 1'b0;
   logic [WW-1:0] mem_m [WORDS];
   logic [WW-1:0] cap0, cap1;
   int            n_vec = 0, n_err = 0;

   ntt_core_seq #(
      .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .Q(998244353), .BF_LAT(BF_LAT),
      .CORE_INDEX(CORE_INDEX), .LOG_CORE_COUNT(LOG_CORE_COUNT), .TW_W(TW_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .log_m(log_m), .i(i_in), .mode(mode),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .tw_index(tw_index), .tw_data(tw_data),
      .busy(busy), .done(done), .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data)
`ifdef NTT_CORE_SEQ_BACKPRESSURE_EN
      , .res_ready(res_ready)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // External twiddle ROM stand-in: an arbitrary fixed map of index to value below Q.
   function automatic longint rom_w(input int idx);
      return (longint'(idx) * 48271 + 12345) % Q;
   endfunction

   always_comb begin
      tw_data = '0;
      for (int j = 0; j < LANES; j++)
         tw_data[j*DATA_W +: DATA_W] = tw_force ? DATA_W'(1)
                                                : DATA_W'(rom_w(int'(tw_index[j*TW_W +: TW_W])));
   end

   function automatic int exp_idx(input int lm, input int gi, input int md, input int addr, input int j);
      int base;
      int r;
      base = (1 << lm) + ((CORE_INDEX << lm) >> LOG_CORE_COUNT);
      if (md == 0)      r = base;
      else if (md == 1) r = base + gi * 2;
      else              r = base + addr * LANES + j;
      return r % (1 << TW_W);
   endfunction

   function automatic logic [WW-1:0] exp_word(input int lm, input int gi, input int md, input int addr);
      logic [WW-1:0] src, r;
      longint a, b, w, p;
      src = mem_m[addr];
      r = '0;
      for (int j = 0; j < LANES; j++) begin
         a = longint'(src[2*j*DATA_W +: DATA_W]);
         b = longint'(src[(2*j+1)*DATA_W +: DATA_W]);
         w = tw_force ? 64'd1 : rom_w(exp_idx(lm, gi, md, addr, j));
         p = (w * b) % Q;
         r[2*j*DATA_W +: DATA_W]     = DATA_W'((a + p) % Q);
         r[(2*j+1)*DATA_W +: DATA_W] = DATA_W'((a - p + Q) % Q);
      end
      return r;
   endfunction

   function automatic logic [WW-1:0] rand_word();
      logic [WW-1:0] d;
      d = '0;
      for (int k = 0; k < 2*LANES; k++) d[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(998244352));
      return d;
   endfunction

   task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One pass: called and returns at a negedge with the DUT idle.
   task automatic run_pass(input int lm, input int gi, input int md, input int abort_at,
                           input bit poke, input bit bp);
      int cyc, base, nres, stall, hold_left, ndone, ta;
      bit fin, bp_seen;
      logic [WW-1:0] hold_dat;
      nres = 0; stall = 0; hold_left = 0; fin = 0; bp_seen = 0; hold_dat = '0;
      log_m = 4'(lm); i_in = 10'(gi); mode = 2'(md); start = 1'b1;
      base = edge_cnt;
      while (!fin) begin
         @(negedge clk);
         cyc = edge_cnt - base;
         start = 1'b0;
         wr_en = 1'b0;
         if (cyc == 1) chk("busy_after_start", busy, 1);
         ta = cyc - 2 - stall;
         if (hold_left == 0 && ta >= 0 && ta < WORDS)
            for (int j = 0; j < LANES; j++)
               chk("tw_index", tw_index[j*TW_W +: TW_W], exp_idx(lm, gi, md, ta, j));
         if (md == 2 && lm == 3 && cyc == 7) begin
            chk("tw_mode2_addr5_lane0", tw_index[0 +: TW_W], 19);
            chk("tw_mode2_addr5_lane1", tw_index[TW_W +: TW_W], 20);
         end
         if (abort_at >= 0 && cyc == abort_at + 1) begin
            rst_n = 1'b0;
            @(negedge clk);
            chk("abort_busy", busy, 0);
            chk("abort_res_valid", res_valid, 0);
            rst_n = 1'b1;
            ndone = 0;
            for (int k = 0; k < 20; k++) begin
               @(negedge clk);
               if (done) ndone++;
            end
            chk("abort_no_done", ndone, 0);
            return;
         end
         if (poke && cyc == 40) begin
            log_m = 4'(lm + 1); i_in = 10'(gi + 7); start = 1'b1;
         end
         if (poke && cyc == 60) begin
            wr_en = 1'b1; wr_addr = 3; wr_data = ~mem_m[3];
         end
         if (bp && !bp_seen && res_valid && res_addr == 10) begin
            bp_seen = 1; hold_left = 7; hold_dat = res_data;
         end
         if (hold_left > 0) begin
            res_ready = 1'b0;
            if (hold_left < 7) begin
               chk("bp_hold_addr", res_addr, 10);
               chk("bp_hold_data", res_data, hold_dat);
            end
            hold_left--;
            stall++;
         end else begin
            res_ready = 1'b1;
         end
         if (res_valid && res_ready) begin
            chk("res_addr", res_addr, nres);
            chk("res_cycle", cyc, 2 + BF_LAT + nres + stall);
            chk("res_data", res_data, exp_word(lm, gi, md, nres));
            if (nres == 0) cap0 = res_data;
            if (nres == 1) cap1 = res_data;
            nres++;
         end
         if (done) begin
            chk("done_cycle", cyc, 3 + BF_LAT + WORDS + stall);
            chk("busy_at_done", busy, 0);
            chk("res_count", nres, WORDS);
            fin = 1;
         end else if (cyc > WORDS + BF_LAT + 60 + stall) begin
            chk("pass_timeout_done", done, 1);
            fin = 1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [WW-1:0] d;
      int ca;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_addr", res_addr, 0);
      chk("rst_res_data", res_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fill the RAM; words 0 and 1 carry the hand-worked butterfly cases.
      for (int a = 0; a < WORDS; a++) begin
         d = rand_word();
         if (a == 0) begin
            d[0 +: DATA_W] = 5;  d[DATA_W +: DATA_W] = 3;
            d[2*DATA_W +: DATA_W] = 1; d[3*DATA_W +: DATA_W] = 2;
         end
         if (a == 1) begin
            d[0 +: DATA_W] = DATA_W'(Q - 1); d[DATA_W +: DATA_W] = 1;
         end
         mem_m[a] = d;
         wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
         @(negedge clk);
      end
      wr_en = 1'b0;
      @(negedge clk);

      tw_force = 1'b1;
      run_pass(0, 0, 0, -1, 0, 0);
      chk("bf_a5_b3_A", cap0[0 +: DATA_W], 8);
      chk("bf_a5_b3_B", cap0[DATA_W +: DATA_W], 2);
      chk("bf_a1_b2_A", cap0[2*DATA_W +: DATA_W], 3);
      chk("bf_a1_b2_B", cap0[3*DATA_W +: DATA_W], Q - 1);
      chk("bf_aQm1_b1_A", cap1[0 +: DATA_W], 0);
      chk("bf_aQm1_b1_B", cap1[DATA_W +: DATA_W], Q - 2);

      tw_force = 1'b0;
      run_pass(3, $urandom_range(1023), 2, -1, 1, 0);

      // Write landing in the same cycle as start must be seen by the pass.
      ca = $urandom_range(511, 100);
      d = rand_word();
      mem_m[ca] = d;
      wr_en = 1'b1; wr_addr = ADDR_W'(ca); wr_data = d;
      run_pass($urandom_range(11), $urandom_range(1023), 1, -1, 0, 0);

      run_pass($urandom_range(15), $urandom_range(1023), 0, 100, 0, 0);
      run_pass($urandom_range(15), $urandom_range(1023), 3, -1, 0, 0);
`ifdef NTT_CORE_SEQ_BACKPRESSURE_EN
      run_pass($urandom_range(15), $urandom_range(1023), 2, -1, 0, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
